// File: rtl/spike_rate_decoder.sv
`default_nettype none
// ============================================================================
// Module      : spike_rate_decoder
// Description : Counts spikes per output neuron over a fixed window of
//               timesteps, then runs a sequential argmax and presents the
//               winning neuron index and count on a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module spike_rate_decoder #(
  parameter int NUM_NEURONS = 10,
  parameter int WINDOW      = 256,
  parameter int COUNT_WIDTH = 16,
  parameter int IDX_WIDTH   = $clog2(NUM_NEURONS)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic                               step_valid,
  input  logic [NUM_NEURONS-1:0]             spike_in,
  output logic                               busy,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [IDX_WIDTH-1:0]               winner_idx,
  output logic [COUNT_WIDTH-1:0]             winner_count,
  output logic                               all_silent,
  output logic [NUM_NEURONS*COUNT_WIDTH-1:0] counts_flat
);

  localparam int                     STEP_W      = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [STEP_W-1:0]      C_LAST_STEP = STEP_W'(WINDOW - 1);
  localparam logic [IDX_WIDTH-1:0]   C_LAST_IDX  = IDX_WIDTH'(NUM_NEURONS - 1);
  localparam logic [COUNT_WIDTH-1:0] C_CNT_MAX   = '1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCUM  = 2'd1,
    S_ARGMAX = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] counts_q [NUM_NEURONS];
  logic [STEP_W-1:0]      step_cnt_q;
  logic [IDX_WIDTH-1:0]   scan_idx_q;
  logic [IDX_WIDTH-1:0]   best_idx_q;
  logic [COUNT_WIDTH-1:0] best_count_q;
  logic [IDX_WIDTH-1:0]   winner_idx_q;
  logic [COUNT_WIDTH-1:0] winner_count_q;
  logic                   all_silent_q;

  logic                   w_cand_gt;
  logic [IDX_WIDTH-1:0]   w_best_idx_d;
  logic [COUNT_WIDTH-1:0] w_best_count_d;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; reset is the only way out of a window besides completion
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_ACCUM;
      S_ACCUM:  if (step_valid && (step_cnt_q == C_LAST_STEP)) state_d = S_ARGMAX;
      S_ARGMAX: if (scan_idx_q == C_LAST_IDX) state_d = S_DONE;
      S_DONE:   if (out_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Argmax candidate: strict compare so the lowest index keeps a tie
  always_comb begin
    w_cand_gt      = (counts_q[scan_idx_q] > best_count_q);
    w_best_idx_d   = w_cand_gt ? scan_idx_q           : best_idx_q;
    w_best_count_d = w_cand_gt ? counts_q[scan_idx_q] : best_count_q;
  end

  // Counters, argmax scan and registered result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_NEURONS; i++) counts_q[i] <= '0;
      step_cnt_q     <= '0;
      scan_idx_q     <= '0;
      best_idx_q     <= '0;
      best_count_q   <= '0;
      winner_idx_q   <= '0;
      winner_count_q <= '0;
      all_silent_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            for (int i = 0; i < NUM_NEURONS; i++) counts_q[i] <= '0;
            step_cnt_q <= '0;
          end
        end
        S_ACCUM: begin
          // Scan state is primed here so ARGMAX starts from a clean best
          scan_idx_q   <= '0;
          best_idx_q   <= '0;
          best_count_q <= '0;
          if (step_valid) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
              if (spike_in[i] && (counts_q[i] != C_CNT_MAX)) counts_q[i] <= counts_q[i] + 1'b1;
            end
            step_cnt_q <= step_cnt_q + 1'b1;
          end
        end
        S_ARGMAX: begin
          best_idx_q   <= w_best_idx_d;
          best_count_q <= w_best_count_d;
          if (scan_idx_q == C_LAST_IDX) begin
            winner_idx_q   <= w_best_idx_d;
            winner_count_q <= w_best_count_d;
            all_silent_q   <= (w_best_count_d == '0);
          end else begin
            scan_idx_q <= scan_idx_q + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) all_silent_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Live counters flattened, neuron i in slice i
  genvar gi;
  generate
    for (gi = 0; gi < NUM_NEURONS; gi++) begin : g_flat
      assign counts_flat[gi*COUNT_WIDTH +: COUNT_WIDTH] = counts_q[gi];
    end
  endgenerate

  assign busy         = (state_q == S_ACCUM) || (state_q == S_ARGMAX);
  assign out_valid    = (state_q == S_DONE);
  assign winner_idx   = winner_idx_q;
  assign winner_count = winner_count_q;
  assign all_silent   = all_silent_q;

endmodule
`default_nettype wire

// File: tb/tb_spike_rate_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_spike_rate_decoder
// Description : Directed self-checking bench; instance A (4 neurons, window 8,
//               4-bit counts) and instance B (4 neurons, window 12, 3-bit
//               counts) for saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spike_rate_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        a_start = 1'b0, a_sv = 1'b0, a_rdy = 1'b0;
  logic [3:0]  a_spk = '0;
  logic        a_busy, a_ov, a_sil;
  logic [1:0]  a_idx;
  logic [3:0]  a_cnt;
  logic [15:0] a_flat;

  logic        b_start = 1'b0, b_sv = 1'b0, b_rdy = 1'b0;
  logic [3:0]  b_spk = '0;
  logic        b_busy, b_ov, b_sil;
  logic [1:0]  b_idx;
  logic [2:0]  b_cnt;
  logic [11:0] b_flat;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  spike_rate_decoder #(.NUM_NEURONS(4), .WINDOW(8), .COUNT_WIDTH(4)) u_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .step_valid(a_sv), .spike_in(a_spk),
    .busy(a_busy), .out_valid(a_ov), .out_ready(a_rdy), .winner_idx(a_idx),
    .winner_count(a_cnt), .all_silent(a_sil), .counts_flat(a_flat));

  spike_rate_decoder #(.NUM_NEURONS(4), .WINDOW(12), .COUNT_WIDTH(3)) u_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .step_valid(b_sv), .spike_in(b_spk),
    .busy(b_busy), .out_valid(b_ov), .out_ready(b_rdy), .winner_idx(b_idx),
    .winner_count(b_cnt), .all_silent(b_sil), .counts_flat(b_flat));

  // Advance one edge; inputs change and outputs are sampled 1ns after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic a_step(input logic [3:0] s);
    a_sv = 1'b1; a_spk = s;
    tick();
    a_sv = 1'b0; a_spk = '0;
  endtask

  task automatic a_gap();
    a_sv = 1'b0; a_spk = 4'hF;
    tick();
    a_spk = '0;
  endtask

  task automatic a_go();
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
  endtask

  task automatic a_accept();
    a_rdy = 1'b1;
    tick();
    a_rdy = 1'b0;
  endtask

  initial begin
    // ---------------- reset ----------------
    tick(); tick();
    rst_n = 1'b1;
    chk("rst_busy", a_busy, 0);
    chk("rst_valid", a_ov, 0);
    chk("rst_idx", a_idx, 0);
    chk("rst_cnt", a_cnt, 0);
    chk("rst_silent", a_sil, 0);
    chk("rst_flat", a_flat, 0);
    chk("rst_b_valid", b_ov, 0);

    // ---------------- basic decode ----------------
    a_go();
    chk("basic_busy", a_busy, 1);
    for (int k = 0; k < 8; k++) a_step((k == 0 || k == 2 || k == 4) ? 4'b0101 : 4'b0100);
    tick(); tick(); tick();
    chk("basic_valid_early", a_ov, 0);
    tick();
    chk("basic_valid", a_ov, 1);
    chk("basic_idx", a_idx, 2);
    chk("basic_cnt", a_cnt, 8);
    chk("basic_silent", a_sil, 0);
    chk("basic_flat", a_flat, 16'h0803);
    a_accept();
    chk("basic_after_valid", a_ov, 0);
    chk("basic_after_busy", a_busy, 0);

    // ---------------- tie with gaps ----------------
    a_go();
    a_step(4'b1010); a_step(4'b1010); a_gap();
    a_step(4'b1010); a_step(4'b1010); a_gap();
    a_step(4'b1010); a_step(4'b0000); a_gap();
    a_step(4'b0000);
    chk("tie_flat_mid", a_flat, 16'h5050);
    chk("tie_still_busy", a_busy, 1);
    chk("tie_no_valid_mid", a_ov, 0);
    a_step(4'b0000);
    tick(); tick(); tick();
    chk("tie_valid_early", a_ov, 0);
    tick();
    chk("tie_valid", a_ov, 1);
    chk("tie_idx", a_idx, 1);
    chk("tie_cnt", a_cnt, 5);
    chk("tie_silent", a_sil, 0);
    a_accept();

    // ---------------- silent window ----------------
    a_go();
    chk("sil_cleared", a_flat, 0);
    for (int k = 0; k < 8; k++) a_step(4'b0000);
    tick(); tick(); tick(); tick();
    chk("sil_valid", a_ov, 1);
    chk("sil_idx", a_idx, 0);
    chk("sil_cnt", a_cnt, 0);
    chk("sil_silent", a_sil, 1);
    a_accept();
    chk("sil_silent_drop", a_sil, 0);

    // ---------------- saturation (instance B) ----------------
    b_start = 1'b1; tick(); b_start = 1'b0;
    for (int k = 0; k < 12; k++) begin
      b_sv = 1'b1; b_spk = 4'b0001; tick();
    end
    b_sv = 1'b0; b_spk = '0;
    tick(); tick(); tick(); tick();
    chk("sat_valid", b_ov, 1);
    chk("sat_idx", b_idx, 0);
    chk("sat_cnt", b_cnt, 7);
    chk("sat_flat", b_flat, 12'h007);
    chk("sat_silent", b_sil, 0);
    b_rdy = 1'b1; tick(); b_rdy = 1'b0;
    chk("sat_after_valid", b_ov, 0);

    // ---------------- backpressure ----------------
    a_go();
    for (int k = 0; k < 8; k++) a_step(4'b0010);
    tick(); tick(); tick(); tick();
    chk("bp_valid0", a_ov, 1);
    for (int k = 0; k < 20; k++) begin
      a_spk = 4'($urandom);
      a_sv = k[0];
      a_start = k[1];
      tick();
      chk("bp_hold_valid", a_ov, 1);
      chk("bp_hold_idx", a_idx, 1);
      chk("bp_hold_cnt", a_cnt, 8);
      chk("bp_hold_flat", a_flat, 16'h0080);
    end
    a_sv = 1'b0; a_spk = '0;
    a_start = 1'b1; a_rdy = 1'b1;
    tick();
    a_start = 1'b0; a_rdy = 1'b0;
    chk("bp_handshake_valid", a_ov, 0);
    chk("bp_start_ignored", a_busy, 0);
    tick();
    chk("bp_idle_busy", a_busy, 0);
    chk("bp_idle_valid", a_ov, 0);
    chk("bp_idle_flat", a_flat, 16'h0080);

    // ---------------- reset mid-operation ----------------
    a_go();
    for (int k = 0; k < 4; k++) a_step(4'b1111);
    chk("mid_flat_pre", a_flat, 16'h4444);
    rst_n = 1'b0;
    a_start = 1'b1;
    tick();
    rst_n = 1'b1;
    a_start = 1'b0;
    chk("mid_busy", a_busy, 0);
    chk("mid_valid", a_ov, 0);
    chk("mid_flat", a_flat, 0);
    chk("mid_idx", a_idx, 0);
    chk("mid_cnt", a_cnt, 0);
    tick();
    chk("mid_idle", a_busy, 0);
    a_go();
    for (int k = 0; k < 8; k++) a_step((k < 6) ? 4'b0001 : 4'b1000);
    tick(); tick(); tick(); tick();
    chk("mid2_valid", a_ov, 1);
    chk("mid2_idx", a_idx, 0);
    chk("mid2_cnt", a_cnt, 6);
    chk("mid2_flat", a_flat, 16'h2006);
    a_accept();

    // ---------------- start ignored while busy ----------------
    a_go();
    for (int k = 0; k < 4; k++) a_step(4'b0110);
    a_start = 1'b1; tick(); a_start = 1'b0;
    chk("sb_no_clear", a_flat, 16'h0440);
    for (int k = 0; k < 4; k++) a_step(4'b0100);
    a_start = 1'b1; tick(); a_start = 1'b0;
    tick(); tick(); tick();
    chk("sb_valid", a_ov, 1);
    chk("sb_idx", a_idx, 2);
    chk("sb_cnt", a_cnt, 8);
    chk("sb_flat", a_flat, 16'h0840);
    a_accept();
    chk("sb_after_valid", a_ov, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spike_rate_decoder.md
Name: spike_rate_decoder

Overview:
- Output-side decoder for the LIF neuron layer. It is the inverse of the input rate encoder: it converts spike trains back into per-neuron spike counts over a fixed window of timesteps.
- After each window it runs a sequential argmax and presents the winning neuron index and its count on a valid/ready output handshake.
- Sits between the output neuron layer and the classification/readout logic.

Parameters:
- NUM_NEURONS, 10, number of output neurons monitored (>=2).
- WINDOW, 256, timesteps per decode window (>=1).
- COUNT_WIDTH, 16, width of each per-neuron spike counter.
- IDX_WIDTH, $clog2(NUM_NEURONS), width of winner index.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  pulse: clear counters and begin a new window (honoured only in IDLE).
- step_valid  input  1  one network timestep completed; spike_in is valid this cycle.
- spike_in  input  NUM_NEURONS  spike flags for this timestep, bit i = neuron i.
- busy  output  1  high in ACCUM and ARGMAX.
- out_valid  output  1  result available (DONE state).
- out_ready  input  1  consumer accepts result.
- winner_idx  output  IDX_WIDTH  index of neuron with highest count.
- winner_count  output  COUNT_WIDTH  count of the winner.
- all_silent  output  1  high with out_valid when winner_count==0.
- counts_flat  output  NUM_NEURONS*COUNT_WIDTH  per-neuron counts; neuron i at bits [i*COUNT_WIDTH +: COUNT_WIDTH].

Behaviour:
- Clock and reset: one clock, clk. rst_n is synchronous and active-low; it is sampled only on the rising edge of clk.
- Reset (rst_n=0 at a clk edge): state=IDLE; all counters, step_cnt, winner_idx, winner_count = 0; busy, out_valid, all_silent = 0.
- Reset mid-operation aborts the window with no output. It overrides every other input in the same cycle.
- FSM states: IDLE, ACCUM, ARGMAX, DONE.
- IDLE:
  - start=1 -> clear all counts and step_cnt, go to ACCUM next cycle.
  - spike_in and step_valid are ignored.
  - counts_flat and winner outputs hold their last values.
- ACCUM:
  - Each cycle with step_valid=1: for every i with spike_in[i]=1, counts[i] += 1, saturating at 2^COUNT_WIDTH-1 (no wrap). step_cnt += 1.
  - Cycles with step_valid=0 change nothing.
  - When step_valid=1 and step_cnt==WINDOW-1, that step is counted and the next state is ARGMAX.
  - start is ignored.
- ARGMAX:
  - Sequential scan, one neuron per cycle, scan_idx 0..NUM_NEURONS-1.
  - Scan starts with best_count=0 and best_idx=0.
  - Update the best when counts[scan_idx] > best_count (strict compare, so on a tie the lowest index wins).
  - After scan_idx==NUM_NEURONS-1 is processed, go to DONE.
  - Takes exactly NUM_NEURONS cycles. spike_in, step_valid and start are ignored.
- DONE:
  - out_valid=1. winner_idx, winner_count and all_silent are registered and held stable while out_valid=1 and out_ready=0.
  - out_ready=1 -> IDLE next cycle, out_valid=0.
  - out_ready may already be high on the first DONE cycle, which gives a single-cycle valid.
- Latency: final step accepted at edge T -> ARGMAX at edges T+1..T+NUM_NEURONS -> out_valid high from cycle T+NUM_NEURONS+1.
- counts_flat:
  - Reflects live counters at all times.
  - Stable from ARGMAX entry until the next accepted start.
- Simultaneous start and out_ready in DONE: out_ready is honoured, start is ignored. A new start is required in IDLE.
- All counts zero: winner_idx=0, winner_count=0, all_silent=1.
- Saturated counts: compared as saturated values; ties between saturated counters resolve to the lowest index.

Test Plan (NUM_NEURONS=4, WINDOW=8, COUNT_WIDTH=4 unless noted):
- Basic decode:
  - Stimulus: start, then 8 steps with spike_in=4'b0100 on all steps, plus 4'b0001 on 3 of them.
  - Response: counts = {0,8,0,3} (neuron 3..0); out_valid exactly 5 cycles after the 8th step edge; winner_idx=2, winner_count=8, all_silent=0.
- Tie, gaps and silence:
  - Stimulus: neurons 1 and 3 each spike 5 times; step_valid deasserted for 3 random cycles between steps.
  - Response: winner_idx=1, winner_count=5; gaps do not advance step_cnt.
  - Stimulus: a separate window with no spikes.
  - Response: winner_idx=0, winner_count=0, all_silent=1.
- Saturation (COUNT_WIDTH=3, WINDOW=12):
  - Stimulus: neuron 0 spikes every step.
  - Response: counts[0]=7, not 4 (no wrap); winner_idx=0, winner_count=7.
- Backpressure:
  - Stimulus: hold out_ready=0 for 20 cycles in DONE while toggling spike_in, step_valid and start.
  - Response: outputs and counts unchanged; on out_ready=1, exactly one handshake, then IDLE.
  - Stimulus: start asserted in the same cycle as out_ready=1.
  - Response: start is ignored.
- Reset mid-operation:
  - Stimulus: rst_n=0 for one cycle after step 4 of a window.
  - Response: next cycle state IDLE, all counts 0, busy=0, out_valid=0, no result emitted.
  - Stimulus: new start followed by a full window.
  - Response: correct result.
- Start ignored while busy:
  - Stimulus: pulse start during ACCUM and during ARGMAX.
  - Response: counters not cleared; result identical to the undisturbed run.
